triangle_vertex_loader: RTL

Initiator side of the triangle-area datapath. It accepts a stream of six 11-bit coordinates over a valid/ready handshake, in the order ax, ay, bx, by, cx, cy. It drives the six coordinate buses of the combinational area (determinant) block and waits a fixed settle time. It then captures the 21-bit determinant and returns magnitude, orientation and degeneracy through a valid/ready result handshake. The block sits between the coordinate source (switch/UART front end) and the area unit.

---
 rtl/triangle_pkg.sv | 22 ++
 rtl/triangle_vertex_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/triangle_pkg.sv
// rtl/triangle_pkg.sv - shared constants and types for the triangle vertex loader
package triangle_pkg;

    localparam int COORD_W = 11;
    localparam int AREA_W  = 21;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] IDX_AX = 3'd0;
    localparam logic [IDX_W-1:0] IDX_AY = 3'd1;
    localparam logic [IDX_W-1:0] IDX_BX = 3'd2;
    localparam logic [IDX_W-1:0] IDX_BY = 3'd3;
    localparam logic [IDX_W-1:0] IDX_CX = 3'd4;
    localparam logic [IDX_W-1:0] IDX_CY = 3'd5;

endpackage

// File: rtl/triangle_vertex_loader.sv
// rtl/triangle_vertex_loader.sv - loads six coordinates, waits for the area unit, returns |det|, orientation and degeneracy
module triangle_vertex_loader #(
    parameter int COORD_W = triangle_pkg::COORD_W,
    parameter int AREA_W  = triangle_pkg::AREA_W,
    parameter int SETTLE  = 2
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] coord_in,
    input  logic               coord_valid,
    output logic               coord_ready,
    output logic [COORD_W-1:0] ax,
    output logic [COORD_W-1:0] ay,
    output logic [COORD_W-1:0] bx,
    output logic [COORD_W-1:0] by,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    input  logic [AREA_W-1:0]  area_in,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [AREA_W-1:0]  res_area,
    output logic               res_cw,
    output logic               res_degenerate,
    output logic               busy
);

    import triangle_pkg::*;

    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] ax_q, ax_d, ay_q, ay_d, bx_q, bx_d;
    logic [COORD_W-1:0] by_q, by_d, cx_q, cx_d, cy_q, cy_d;
    logic [AREA_W-1:0]  res_area_q, res_area_d;
    logic               res_cw_q, res_cw_d;
    logic               res_degenerate_q, res_degenerate_d;

    logic               load_fire;
    logic               settle_done;
    logic [AREA_W-1:0]  area_mag;

    // Handshake and settle-timer conditions shared by next-state and datapath logic
    always_comb begin
        load_fire   = (state_q == ST_LOAD) && coord_valid;
        settle_done = (state_q == ST_SETTLE) && (cnt_q == SETTLE_CNT);
        // The most negative determinant maps to 2^(AREA_W-1), still representable unsigned
        area_mag    = area_in[AREA_W-1] ? ((~area_in) + AREA_W'(1)) : area_in;
    end

    // All state flops; async assert clears the outputs the moment reset_n falls
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_LOAD;
            idx_q            <= '0;
            cnt_q            <= '0;
            ax_q             <= '0;
            ay_q             <= '0;
            bx_q             <= '0;
            by_q             <= '0;
            cx_q             <= '0;
            cy_q             <= '0;
            res_area_q       <= '0;
            res_cw_q         <= 1'b0;
            res_degenerate_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            cnt_q            <= cnt_d;
            ax_q             <= ax_d;
            ay_q             <= ay_d;
            bx_q             <= bx_d;
            by_q             <= by_d;
            cx_q             <= cx_d;
            cy_q             <= cy_d;
            res_area_q       <= res_area_d;
            res_cw_q         <= res_cw_d;
            res_degenerate_q <= res_degenerate_d;
        end
    end

    // Next-state: load six words, settle, then hold the result until consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:   if (load_fire && (idx_q == IDX_CY)) state_d = ST_SETTLE;
            ST_SETTLE: if (settle_done) state_d = ST_RESULT;
            ST_RESULT: if (res_ready) state_d = ST_LOAD;
            default:   state_d = ST_LOAD;
        endcase
    end

    // Datapath: coordinate write-by-index, settle counter and result capture
    always_comb begin
        idx_d            = idx_q;
        cnt_d            = cnt_q;
        ax_d             = ax_q;
        ay_d             = ay_q;
        bx_d             = bx_q;
        by_d             = by_q;
        cx_d             = cx_q;
        cy_d             = cy_q;
        res_area_d       = res_area_q;
        res_cw_d         = res_cw_q;
        res_degenerate_d = res_degenerate_q;

        if (load_fire) begin
            case (idx_q)
                IDX_AX:  ax_d = coord_in;
                IDX_AY:  ay_d = coord_in;
                IDX_BX:  bx_d = coord_in;
                IDX_BY:  by_d = coord_in;
                IDX_CX:  cx_d = coord_in;
                default: cy_d = coord_in;
            endcase
            if (idx_q == IDX_CY) begin
                idx_d = '0;
                cnt_d = '0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        if (state_q == ST_SETTLE) begin
            if (settle_done) begin
                res_area_d       = area_mag;
                res_cw_d         = area_in[AREA_W-1];
                res_degenerate_d = (area_in == '0);
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        coord_ready    = (state_q == ST_LOAD);
        res_valid      = (state_q == ST_RESULT);
        busy           = (state_q != ST_LOAD);
        ax             = ax_q;
        ay             = ay_q;
        bx             = bx_q;
        by             = by_q;
        cx             = cx_q;
        cy             = cy_q;
        res_area       = res_area_q;
        res_cw         = res_cw_q;
        res_degenerate = res_degenerate_q;
    end

endmodule
